overworld_renderer: RTL and testbench

- Consumer end of the player-controller interface: it turns player map position, sprite-sheet selection and battle_trigger into screen pixels.
- Computes map-ROM and sprite-ROM addresses from hcount/vcount and the player's map_x/map_y.
- Composites the 16x16 player sprite over the scrolled map, with a transparency key.
- Runs the battle-transition FSM (flash, then wipe) and holds battle_active until the battle engine returns control. Sits between the XVGA timing generator and the VGA output register.

---
 rtl/render_pkg.sv | 13 +
 rtl/battle_transition_fsm.sv | 81 ++++++++
 rtl/overworld_renderer.sv | 132 +++++++++++++
 tb/tb_overworld_renderer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the overworld renderer: FSM state encoding,
// screen geometry and pipeline depth.
package render_pkg;

    typedef enum logic [1:0] {IDLE, FLASH, WIPE, DONE} state_t;

    typedef logic [11:0] rgb_t;

    localparam int unsigned H_VIS = 1024;
    localparam int unsigned V_VIS = 768;
    localparam int unsigned PIPE  = 4;

endpackage

// File: rtl/battle_transition_fsm.sv
// Battle transition sequencer: flash for 32 frames, grow the wipe bars until
// they meet mid-screen, then hold the battle screen until the engine hands back.
module battle_transition_fsm
    import render_pkg::*;
#(
    parameter int unsigned WIPE_STEP = 16
) (
    input  logic       vclk,
    input  logic       reset,
    input  logic       tick,
    input  logic       battle_trigger,
    input  logic       battle_done,
    output state_t     state,
    output logic [4:0] fcnt,
    output logic [9:0] bar,
    output logic       battle_active
);

    state_t      state_q, state_d;
    logic [4:0]  fcnt_q, fcnt_d;
    logic [9:0]  bar_q, bar_d;
    logic [10:0] bar_sum;
    logic        active_q;

    always_ff @(posedge vclk) begin
        if (reset) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            bar_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            bar_q    <= bar_d;
            active_q <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        bar_d   = bar_q;
        bar_sum = {1'b0, bar_q} + 11'(WIPE_STEP);
        case (state_q)
            IDLE: begin
                // A tick coinciding with the trigger is not counted.
                if (battle_trigger) begin
                    state_d = FLASH;
                    fcnt_d  = '0;
                end
            end
            FLASH: begin
                if (tick) begin
                    fcnt_d = fcnt_q + 5'd1;
                    if (fcnt_q == 5'd31) begin
                        state_d = WIPE;
                        bar_d   = '0;
                    end
                end
            end
            WIPE: begin
                if (tick) begin
                    bar_d = bar_sum[9:0];
                    if (bar_sum >= 11'(V_VIS / 2)) state_d = DONE;
                end
            end
            DONE: begin
                if (battle_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state         = state_q;
        fcnt          = fcnt_q;
        bar           = bar_q;
        battle_active = active_q;
    end

endmodule

// File: rtl/overworld_renderer.sv
// Overworld pixel pipeline: scrolled map plus fixed-position player sprite,
// composited and overlaid with the battle transition, 4 cycles input to pixel.
module overworld_renderer
    import render_pkg::*;
#(
    parameter int unsigned MAP_W     = 512,
    parameter int unsigned MAP_H     = 512,
    parameter int unsigned SPR_X     = 504,
    parameter int unsigned SPR_Y     = 376,
    parameter rgb_t        TRANSP    = 12'h0F0,
    parameter rgb_t        BORDER    = 12'h000,
    parameter int unsigned WIPE_STEP = 16
) (
    input  logic        vclk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [10:0] map_x,
    input  logic [9:0]  map_y,
    input  logic [5:0]  sprite_sel_x,
    input  logic [5:0]  sprite_sel_y,
    input  logic        battle_trigger,
    input  logic        battle_done,
    output logic [17:0] map_addr,
    input  rgb_t        map_data,
    output logic [11:0] sprite_addr,
    input  rgb_t        sprite_data,
    output rgb_t        pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        battle_active
);

    logic signed [11:0] wx, wy, sx, sy;
    logic               in_map, in_spr, tick;
    logic [17:0]        map_addr_d, map_addr_q;
    logic [11:0]        spr_row, sprite_addr_d, sprite_addr_q;

    logic [PIPE-2:0]        in_map_p, in_spr_p;
    logic [PIPE-1:0]        hs_p, vs_p, bl_p;
    logic [PIPE-2:0][9:0]   vrow_p;
    logic [9:0]             vrow;
    rgb_t                   color, pixel_d, pixel_q;

    state_t     state;
    logic [4:0] fcnt;
    logic [9:0] bar;

    assign tick = (hcount == 11'd0) && (vcount == 10'd0);

    battle_transition_fsm #(
        .WIPE_STEP (WIPE_STEP)
    ) u_fsm (
        .vclk           (vclk),
        .reset          (reset),
        .tick           (tick),
        .battle_trigger (battle_trigger),
        .battle_done    (battle_done),
        .state          (state),
        .fcnt           (fcnt),
        .bar            (bar),
        .battle_active  (battle_active)
    );

    // Signed differences so positions left of / above the map never wrap into it.
    always_comb begin
        wx = $signed({1'b0, hcount}) - $signed({1'b0, map_x});
        wy = $signed({2'b00, vcount}) - $signed({2'b00, map_y});
        sx = $signed({1'b0, hcount}) - $signed(12'(SPR_X));
        sy = $signed({2'b00, vcount}) - $signed(12'(SPR_Y));
        in_map = !wx[11] && (wx[10:0] < 11'(MAP_W)) && !wy[11] && (wy[10:0] < 11'(MAP_H));
        in_spr = !sx[11] && (sx[10:0] < 11'd16) && !sy[11] && (sy[10:0] < 11'd16);
        map_addr_d = in_map ? 18'(32'(wy[10:0]) * MAP_W + 32'(wx[10:0])) : '0;
        spr_row = 12'(sprite_sel_y) + 12'(sy[3:0]);
        sprite_addr_d = in_spr ? (spr_row << 6) + 12'(sprite_sel_x) + 12'(sx[3:0]) : '0;
    end

    always_ff @(posedge vclk) begin
        if (reset) begin
            map_addr_q    <= '0;
            sprite_addr_q <= '0;
            in_map_p      <= '0;
            in_spr_p      <= '0;
            hs_p          <= '0;
            vs_p          <= '0;
            bl_p          <= '0;
            vrow_p        <= '0;
            pixel_q       <= '0;
        end else begin
            map_addr_q    <= map_addr_d;
            sprite_addr_q <= sprite_addr_d;
            in_map_p      <= {in_map_p[PIPE-3:0], in_map};
            in_spr_p      <= {in_spr_p[PIPE-3:0], in_spr};
            hs_p          <= {hs_p[PIPE-2:0], hsync_in};
            vs_p          <= {vs_p[PIPE-2:0], vsync_in};
            bl_p          <= {bl_p[PIPE-2:0], blank_in};
            vrow_p        <= {vrow_p[PIPE-3:0], vcount};
            pixel_q       <= pixel_d;
        end
    end

    assign vrow = vrow_p[PIPE-2];

    always_comb begin
        color = BORDER;
        if (in_spr_p[PIPE-2] && (sprite_data != TRANSP)) color = sprite_data;
        else if (in_map_p[PIPE-2]) color = map_data;

        pixel_d = color;
        case (state)
            FLASH: if ((fcnt & 5'b01000) == 5'd0) pixel_d = ~color;
            WIPE: begin
                if ((vrow < bar) || ({1'b0, vrow} >= 11'(V_VIS) - {1'b0, bar})) pixel_d = '0;
            end
            DONE: pixel_d = '0;
            default: pixel_d = color;
        endcase
        if (bl_p[PIPE-2]) pixel_d = '0;
    end

    assign map_addr    = map_addr_q;
    assign sprite_addr = sprite_addr_q;
    assign pixel_out   = pixel_q;
    assign hsync_out   = hs_p[PIPE-1];
    assign vsync_out   = vs_p[PIPE-1];
    assign blank_out   = bl_p[PIPE-1];

endmodule

// File: tb/tb_overworld_renderer.sv
// Scoreboard bench for overworld_renderer: one-cycle directed vectors push
// expected address/pixel records; a monitor pops them at the matching latency.
module tb_overworld_renderer;

    logic        vclk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync_in, vsync_in, blank_in;
    logic [10:0] map_x;
    logic [9:0]  map_y;
    logic [5:0]  sprite_sel_x, sprite_sel_y;
    logic        battle_trigger, battle_done;
    logic [17:0] map_addr;
    logic [11:0] map_data = '0;
    logic [11:0] sprite_addr;
    logic [11:0] sprite_data = '0;
    logic [11:0] pixel_out;
    logic        hsync_out, vsync_out, blank_out, battle_active;

    overworld_renderer dut (
        .vclk           (vclk),
        .reset          (reset),
        .hcount         (hcount),
        .vcount         (vcount),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .blank_in       (blank_in),
        .map_x          (map_x),
        .map_y          (map_y),
        .sprite_sel_x   (sprite_sel_x),
        .sprite_sel_y   (sprite_sel_y),
        .battle_trigger (battle_trigger),
        .battle_done    (battle_done),
        .map_addr       (map_addr),
        .map_data       (map_data),
        .sprite_addr    (sprite_addr),
        .sprite_data    (sprite_data),
        .pixel_out      (pixel_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_out      (blank_out),
        .battle_active  (battle_active)
    );

    always #5 vclk = ~vclk;

    // ROM models: contents are uniform, 2-cycle latency.
    logic [11:0] map_val = '0, spr_val = '0, map_d1 = '0, spr_d1 = '0;
    always @(posedge vclk) begin
        map_d1      <= map_val;
        map_data    <= map_d1;
        spr_d1      <= spr_val;
        sprite_data <= spr_d1;
    end

    typedef struct {
        int          id;
        logic [17:0] ma;
        logic [11:0] sa;
    } addr_exp_t;

    typedef struct {
        int          id;
        logic [11:0] pix;
        logic        hs, vs, bl, act;
    } pix_exp_t;

    addr_exp_t aq[$];
    pix_exp_t  pq[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   vid      = 0;
    logic issue    = 1'b0;
    logic taga     = 1'b0;
    logic [3:0] tagp = '0;

    always @(posedge vclk) begin
        taga <= issue;
        tagp <= {tagp[2:0], issue};
    end

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    endtask

    always @(negedge vclk) begin
        if (taga) begin
            if (aq.size() == 0) begin
                n_checks++;
                $display("FAIL addr_queue: got empty queue, expected an entry");
            end else begin
                addr_exp_t a;
                a = aq.pop_front();
                chk("map_addr", a.id, 32'(map_addr), 32'(a.ma));
                chk("sprite_addr", a.id, 32'(sprite_addr), 32'(a.sa));
            end
        end
        if (tagp[3]) begin
            if (pq.size() == 0) begin
                n_checks++;
                $display("FAIL pix_queue: got empty queue, expected an entry");
            end else begin
                pix_exp_t p;
                p = pq.pop_front();
                chk("pixel_out", p.id, 32'(pixel_out), 32'(p.pix));
                chk("hsync_out", p.id, 32'(hsync_out), 32'(p.hs));
                chk("vsync_out", p.id, 32'(vsync_out), 32'(p.vs));
                chk("blank_out", p.id, 32'(blank_out), 32'(p.bl));
                chk("battle_active", p.id, 32'(battle_active), 32'(p.act));
            end
        end
    end

    task automatic step();
        @(posedge vclk);
        #1;
    endtask

    task automatic neutral();
        hcount         = 11'd5;
        vcount         = 10'd5;
        hsync_in       = 1'b0;
        vsync_in       = 1'b0;
        blank_in       = 1'b0;
        battle_trigger = 1'b0;
        battle_done    = 1'b0;
    endtask

    task automatic vec(input int h, input int v, input logic hs, input logic vs,
                       input logic bl, input logic [17:0] ema, input logic [11:0] esa,
                       input logic [11:0] epix, input logic eact);
        addr_exp_t a;
        pix_exp_t  p;
        vid++;
        hcount   = 11'(h);
        vcount   = 10'(v);
        hsync_in = hs;
        vsync_in = vs;
        blank_in = bl;
        a.id = vid; a.ma = ema; a.sa = esa;
        p.id = vid; p.pix = epix; p.hs = hs; p.vs = vs; p.bl = bl; p.act = eact;
        aq.push_back(a);
        pq.push_back(p);
        issue = 1'b1;
        step();
        issue = 1'b0;
        neutral();
        repeat (5) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            hcount = 11'd0;
            vcount = 10'd0;
            step();
            neutral();
            step();
        end
    endtask

    task automatic pulse_trigger();
        battle_trigger = 1'b1;
        step();
        neutral();
        step();
    endtask

    task automatic pulse_done();
        battle_done = 1'b1;
        step();
        neutral();
        step();
    endtask

    initial begin
        neutral();
        hsync_in = 1'b1; vsync_in = 1'b1; hcount = 11'd600; vcount = 10'd400;
        reset = 1'b1;
        map_x = 11'd432; map_y = 10'd312;
        sprite_sel_x = 6'd0; sprite_sel_y = 6'd0;
        map_val = 12'hABC; spr_val = 12'hF00;
        repeat (3) step();
        @(negedge vclk);
        chk("rst_pixel_out", 0, 32'(pixel_out), 32'h0);
        chk("rst_hsync_out", 0, 32'(hsync_out), 32'h0);
        chk("rst_vsync_out", 0, 32'(vsync_out), 32'h0);
        chk("rst_blank_out", 0, 32'(blank_out), 32'h0);
        chk("rst_map_addr", 0, 32'(map_addr), 32'h0);
        chk("rst_sprite_addr", 0, 32'(sprite_addr), 32'h0);
        chk("rst_battle_active", 0, 32'(battle_active), 32'h0);
        step();
        reset = 1'b0;
        neutral();
        step();

        // Map lookup, out-of-map border, map edge.
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'hABC, 0);
        vec(100, 50, 0, 0, 0, 18'd0, 12'd0, 12'h000, 0);
        vec(943, 400, 0, 0, 0, 18'd45567, 12'd0, 12'hABC, 0);
        vec(944, 400, 0, 0, 0, 18'd0, 12'd0, 12'h000, 0);

        // Sprite addressing, transparency and sprite edges.
        sprite_sel_x = 6'd16; sprite_sel_y = 6'd32;
        vec(507, 381, 0, 0, 0, 18'd35403, 12'd2387, 12'hF00, 0);
        spr_val = 12'h0F0;
        vec(507, 381, 0, 0, 0, 18'd35403, 12'd2387, 12'hABC, 0);
        spr_val = 12'hF00;
        vec(519, 391, 0, 0, 0, 18'd40535, 12'd3039, 12'hF00, 0);
        vec(520, 391, 0, 0, 0, 18'd40536, 12'd0, 12'hABC, 0);
        vec(507, 392, 0, 0, 0, 18'd41035, 12'd0, 12'hABC, 0);

        // Timing pass-through and blanking.
        vec(600, 400, 1, 0, 0, 18'd45224, 12'd0, 12'hABC, 0);
        vec(600, 400, 1, 1, 1, 18'd45224, 12'd0, 12'h000, 0);
        vec(600, 400, 0, 1, 0, 18'd45224, 12'd0, 12'hABC, 0);

        // Battle transition; trigger lands on a tick, which must not count.
        map_val = 12'h123;
        hcount = 11'd0; vcount = 10'd0; battle_trigger = 1'b1;
        step();
        neutral();
        step();
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'hEDC, 0);
        pulse_done();
        ticks(7);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'hEDC, 0);
        ticks(1);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'h123, 0);
        pulse_trigger();
        ticks(7);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'h123, 0);
        ticks(1);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'hEDC, 0);
        ticks(15);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'h123, 0);
        ticks(1);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'h123, 0);
        ticks(1);
        map_y = 10'd0;
        vec(600, 10, 0, 0, 0, 18'd5288, 12'd0, 12'h000, 0);
        vec(600, 16, 0, 0, 0, 18'd8360, 12'd0, 12'h123, 0);
        map_y = 10'd300;
        vec(600, 751, 0, 0, 0, 18'd231080, 12'd0, 12'h123, 0);
        vec(600, 752, 0, 0, 0, 18'd231592, 12'd0, 12'h000, 0);
        map_y = 10'd312;
        ticks(22);
        vec(600, 383, 0, 0, 0, 18'd36520, 12'd0, 12'h123, 0);
        vec(600, 400, 0, 0, 0, 18'd45224, 12'd0, 12'h000, 0);
        ticks(1);
        vec(600, 383, 0, 0, 0, 18'd36520, 12'd0, 12'h000, 1);
        pulse_done();
        vec(600, 383, 0, 0, 0, 18'd36520, 12'd0, 12'h123, 0);

        // Reset in the middle of the wipe.
        pulse_trigger();
        ticks(33);
        map_y = 10'd0;
        vec(600, 10, 0, 0, 0, 18'd5288, 12'd0, 12'h000, 0);
        reset = 1'b1;
        repeat (2) step();
        @(negedge vclk);
        chk("wipe_rst_pixel_out", 0, 32'(pixel_out), 32'h0);
        chk("wipe_rst_battle_active", 0, 32'(battle_active), 32'h0);
        step();
        reset = 1'b0;
        step();
        vec(600, 10, 0, 0, 0, 18'd5288, 12'd0, 12'h123, 0);

        repeat (3) step();
        chk("addr_queue_drained", 0, 32'(aq.size()), 32'd0);
        chk("pix_queue_drained", 0, 32'(pq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
